// File: rtl/data_distributor_pkg.sv
// -----------------------------------------------------------------------------
// data_dist_pkg
// Shared constants and types for the data_distributor block: channel count,
// select width, per-channel FIFO depth and occupancy width, plus the
// occupancy update rule used by every channel buffer.
// -----------------------------------------------------------------------------
package data_dist_pkg;

  localparam int NCH   = 4;  // number of output channels
  localparam int SEL_W = 2;  // width of the destination select
  localparam int DEPTH = 2;  // entries per channel buffer
  localparam int CNT_W = 2;  // occupancy width, holds 0..DEPTH

  typedef logic [SEL_W-1:0] chan_sel_t;

  // Occupancy after one edge given the already-qualified push and pop.
  // A simultaneous push and pop leaves the count unchanged.
  function automatic logic [CNT_W-1:0] occ_next(input logic [CNT_W-1:0] cnt,
                                                input logic             push,
                                                input logic             pop);
    logic [CNT_W-1:0] nxt;
    nxt = cnt;
    if (push && !pop) begin
      nxt = cnt + CNT_W'(1);
    end else if (pop && !push) begin
      nxt = cnt - CNT_W'(1);
    end
    return nxt;
  endfunction

endpackage

// File: rtl/data_distributor_if.sv
// -----------------------------------------------------------------------------
// data_distributor_if
// Bundles the producer handshake and the four consumer channels of the
// data_distributor.
//   in_valid / in_ready / in_sel / in_data : single producer, routed by in_sel
//   out_valid[i] / out_ready[i]            : consumer i handshake
//   out_data0..out_data3                   : head word of each channel
//   out_count                              : {c3,c2,c1,c0}, 2 bits per channel
// Modports:
//   slave  : the distributor itself
//   master : the environment (producer plus the four consumers)
// -----------------------------------------------------------------------------
interface data_distributor_if #(
  parameter int WIDTH = 8
);
  import data_dist_pkg::*;

  logic                   in_valid;
  logic                   in_ready;
  chan_sel_t              in_sel;
  logic [WIDTH-1:0]       in_data;
  logic [NCH-1:0]         out_valid;
  logic [NCH-1:0]         out_ready;
  logic [WIDTH-1:0]       out_data0;
  logic [WIDTH-1:0]       out_data1;
  logic [WIDTH-1:0]       out_data2;
  logic [WIDTH-1:0]       out_data3;
  logic [NCH*CNT_W-1:0]   out_count;

  modport slave (
    input  in_valid,
    input  in_sel,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data0,
    output out_data1,
    output out_data2,
    output out_data3,
    output out_count
  );

  modport master (
    output in_valid,
    output in_sel,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data0,
    input  out_data1,
    input  out_data2,
    input  out_data3,
    input  out_count
  );

endinterface

// File: rtl/data_distributor_chan_fifo2.sv
// -----------------------------------------------------------------------------
// chan_fifo2
// Two-entry FIFO used as one output channel of the data_distributor.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (clears storage too)
//   push, din  : write request and word; ignored while full
//   pop        : remove head; ignored while empty
//   dout       : head word (storage register selected by the read pointer)
//   valid      : buffer non-empty
//   full       : buffer holds DEPTH words
//   count      : occupancy 0..DEPTH
// There is no bypass: a word pushed at an edge first appears on dout in the
// following cycle. A pop on an empty buffer is dropped even when a push
// arrives in the same edge, so that push simply lands as the only entry.
// -----------------------------------------------------------------------------
module chan_fifo2
  import data_dist_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic             full,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_valid;

  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_valid = (r_count != '0);

  // Qualify requests against occupancy before they touch any state.
  assign w_push = push & ~w_full;
  assign w_pop  = pop  &  w_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        r_mem[k] <= '0;
      end
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= din;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= occ_next(r_count, w_push, w_pop);
    end
  end

  assign dout  = r_mem[r_rd_ptr];
  assign valid = w_valid;
  assign full  = w_full;
  assign count = r_count;

endmodule

// File: rtl/data_distributor.sv
// -----------------------------------------------------------------------------
// data_distributor
// Routes one producer byte stream into four independently drained channels,
// each backed by a 2-entry chan_fifo2, so a stalled consumer never blocks
// traffic bound for the other channels.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset; discards every buffered word
//   bus   : data_distributor_if.slave (producer handshake, four consumer
//           handshakes, head words and packed occupancy)
// in_ready is the only combinational output and depends solely on in_sel and
// registered occupancy, never on out_ready, so there is no ready
// pass-through path from the consumers to the producer.
// -----------------------------------------------------------------------------
module data_distributor
  import data_dist_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  data_distributor_if.slave    bus
);

  logic [NCH-1:0]   w_push;
  logic [NCH-1:0]   w_full;
  logic [NCH-1:0]   w_valid;
  logic [WIDTH-1:0] w_dout  [NCH];
  logic [CNT_W-1:0] w_count [NCH];
  logic             w_in_ready;

  // A full channel refuses new words even if its consumer pops this edge.
  assign w_in_ready  = ~w_full[bus.in_sel];
  assign bus.in_ready = w_in_ready;

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    assign w_push[g] = bus.in_valid & w_in_ready & (bus.in_sel == chan_sel_t'(g));

    chan_fifo2 #(
      .WIDTH (WIDTH)
    ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (w_push[g]),
      .pop   (bus.out_ready[g]),
      .din   (bus.in_data),
      .dout  (w_dout[g]),
      .valid (w_valid[g]),
      .full  (w_full[g]),
      .count (w_count[g])
    );

    assign bus.out_count[g*CNT_W +: CNT_W] = w_count[g];
  end

  assign bus.out_valid = w_valid;
  assign bus.out_data0 = w_dout[0];
  assign bus.out_data1 = w_dout[1];
  assign bus.out_data2 = w_dout[2];
  assign bus.out_data3 = w_dout[3];

endmodule

// File: tb/tb_data_distributor.sv
module tb_data_distributor;

  logic clk;
  logic rst_n;

  data_distributor_if #(.WIDTH(8)) bus ();

  data_distributor #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic       vld;
    logic [1:0] sel;
    logic [7:0] din;
    logic [3:0] ordy;
    logic       exp_rdy;    // in_ready before the edge
    logic [3:0] exp_valid;  // after the edge
    logic [7:0] exp_cnt;    // after the edge
    logic [1:0] chk_ch;     // channel whose head is checked
    logic [7:0] exp_head;   // checked only when exp_valid[chk_ch]
  } vec_t;

  vec_t vt [20];

  // Reference model: one queue of words per channel.
  logic [7:0] mq [4][$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] head_of(input int ch);
    case (ch)
      0:       return bus.out_data0;
      1:       return bus.out_data1;
      2:       return bus.out_data2;
      default: return bus.out_data3;
    endcase
  endfunction

  task automatic drive(input logic vld, input logic [1:0] sel, input logic [7:0] din,
                       input logic [3:0] ordy);
    bus.in_valid  = vld;
    bus.in_sel    = sel;
    bus.in_data   = din;
    bus.out_ready = ordy;
  endtask

  task automatic push_one(input logic [1:0] sel, input logic [7:0] din);
    drive(1'b1, sel, din, 4'b0000);
    @(posedge clk);
    #1;
  endtask

  // Compare all outputs against the model queues.
  task automatic compare_model(input string tag);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s_valid%0d", tag, i), 32'(bus.out_valid[i]), 32'(mq[i].size() > 0));
      chk($sformatf("%s_cnt%0d", tag, i), 32'(bus.out_count[2*i +: 2]), 32'(mq[i].size()));
      if (mq[i].size() > 0) begin
        chk($sformatf("%s_data%0d", tag, i), 32'(head_of(i)), 32'(mq[i][0]));
      end
    end
  endtask

  initial begin
    logic       p_vld;
    logic [1:0] p_sel;
    logic [7:0] p_data;
    logic [3:0] ordy;
    logic       acc;

    // ---------------- reset state ----------------
    rst_n = 1'b0;
    drive(1'b0, 2'd0, 8'h00, 4'b0000);
    #1;
    chk("rst_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_count", 32'(bus.out_count), 32'h0);
    chk("rst_ready", 32'(bus.in_ready), 32'h1);
    chk("rst_data", {bus.out_data3, bus.out_data2, bus.out_data1, bus.out_data0}, 32'h0);
    #11;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // ---------------- table-driven directed vectors ----------------
    vt[0]  = '{1'b1, 2'd2, 8'hA1, 4'b0000, 1'b1, 4'b0100, 8'h10, 2'd2, 8'hA1};
    vt[1]  = '{1'b1, 2'd0, 8'h11, 4'b0000, 1'b1, 4'b0101, 8'h11, 2'd0, 8'h11};
    vt[2]  = '{1'b1, 2'd0, 8'h22, 4'b0000, 1'b1, 4'b0101, 8'h12, 2'd0, 8'h11};
    vt[3]  = '{1'b1, 2'd0, 8'h33, 4'b0000, 1'b0, 4'b0101, 8'h12, 2'd0, 8'h11};
    vt[4]  = '{1'b1, 2'd0, 8'h33, 4'b0001, 1'b0, 4'b0101, 8'h11, 2'd0, 8'h22};
    vt[5]  = '{1'b1, 2'd0, 8'h33, 4'b0000, 1'b1, 4'b0101, 8'h12, 2'd0, 8'h22};
    vt[6]  = '{1'b0, 2'd0, 8'h00, 4'b0001, 1'b0, 4'b0101, 8'h11, 2'd0, 8'h33};
    vt[7]  = '{1'b0, 2'd0, 8'h00, 4'b0001, 1'b1, 4'b0100, 8'h10, 2'd2, 8'hA1};
    vt[8]  = '{1'b0, 2'd0, 8'h00, 4'b0100, 1'b1, 4'b0000, 8'h00, 2'd0, 8'h00};
    vt[9]  = '{1'b1, 2'd1, 8'hB1, 4'b0000, 1'b1, 4'b0010, 8'h04, 2'd1, 8'hB1};
    vt[10] = '{1'b1, 2'd1, 8'hB2, 4'b0000, 1'b1, 4'b0010, 8'h08, 2'd1, 8'hB1};
    vt[11] = '{1'b1, 2'd3, 8'h5C, 4'b0000, 1'b1, 4'b1010, 8'h48, 2'd3, 8'h5C};
    vt[12] = '{1'b0, 2'd1, 8'h00, 4'b0000, 1'b0, 4'b1010, 8'h48, 2'd1, 8'hB1};
    vt[13] = '{1'b0, 2'd1, 8'h00, 4'b1010, 1'b0, 4'b0010, 8'h04, 2'd1, 8'hB2};
    vt[14] = '{1'b0, 2'd1, 8'h00, 4'b0010, 1'b1, 4'b0000, 8'h00, 2'd1, 8'h00};
    vt[15] = '{1'b1, 2'd0, 8'h01, 4'b0000, 1'b1, 4'b0001, 8'h01, 2'd0, 8'h01};
    vt[16] = '{1'b1, 2'd0, 8'h02, 4'b0001, 1'b1, 4'b0001, 8'h01, 2'd0, 8'h02};
    vt[17] = '{1'b0, 2'd0, 8'h00, 4'b0001, 1'b1, 4'b0000, 8'h00, 2'd0, 8'h00};
    vt[18] = '{1'b1, 2'd0, 8'h7E, 4'b0001, 1'b1, 4'b0001, 8'h01, 2'd0, 8'h7E};
    vt[19] = '{1'b0, 2'd0, 8'h00, 4'b0001, 1'b1, 4'b0000, 8'h00, 2'd0, 8'h00};

    for (int v = 0; v < 20; v++) begin
      drive(vt[v].vld, vt[v].sel, vt[v].din, vt[v].ordy);
      #1;
      chk($sformatf("vec%0d_ready", v), 32'(bus.in_ready), 32'(vt[v].exp_rdy));
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_valid", v), 32'(bus.out_valid), 32'(vt[v].exp_valid));
      chk($sformatf("vec%0d_count", v), 32'(bus.out_count), 32'(vt[v].exp_cnt));
      if (vt[v].exp_valid[vt[v].chk_ch]) begin
        chk($sformatf("vec%0d_head", v), 32'(head_of(int'(vt[v].chk_ch))), 32'(vt[v].exp_head));
      end
    end

    // ---------------- asynchronous reset mid-operation ----------------
    for (int c = 0; c < 4; c++) begin
      push_one(2'(c), 8'(8'h40 + c));
      push_one(2'(c), 8'(8'h50 + c));
    end
    drive(1'b0, 2'd0, 8'h00, 4'b0000);
    chk("full_valid", 32'(bus.out_valid), 32'hF);
    chk("full_count", 32'(bus.out_count), 32'hAA);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(bus.out_valid), 32'h0);
    chk("mid_rst_count", 32'(bus.out_count), 32'h0);
    chk("mid_rst_data", {bus.out_data3, bus.out_data2, bus.out_data1, bus.out_data0}, 32'h0);
    chk("mid_rst_ready", 32'(bus.in_ready), 32'h1);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    push_one(2'd1, 8'h99);
    drive(1'b0, 2'd0, 8'h00, 4'b0000);
    chk("post_rst_valid", 32'(bus.out_valid), 32'h2);
    chk("post_rst_count", 32'(bus.out_count), 32'h04);
    chk("post_rst_data", {bus.out_data3, bus.out_data2, bus.out_data1, bus.out_data0}, 32'h0000_9900);
    drive(1'b0, 2'd0, 8'h00, 4'b0010);
    @(posedge clk);
    #1;
    chk("post_rst_drain", 32'(bus.out_valid), 32'h0);

    // ---------------- randomized run against the queue model ----------------
    p_vld  = 1'b0;
    p_sel  = 2'd0;
    p_data = 8'h00;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (!p_vld) begin
        p_vld  = ($urandom_range(0, 3) != 0);
        p_sel  = 2'($urandom_range(0, 3));
        p_data = 8'($urandom);
      end
      ordy = 4'($urandom);
      if (cyc % 500 < 100) ordy = 4'b0000;      // stall bursts fill channels
      if (cyc % 500 >= 400) ordy = 4'b1111;     // streaming bursts
      drive(p_vld, p_sel, p_data, ordy);
      #1;
      chk("rnd_ready", 32'(bus.in_ready), 32'(mq[p_sel].size() < 2));
      acc = p_vld && (mq[p_sel].size() < 2);
      @(posedge clk);
      for (int i = 0; i < 4; i++) begin
        if (ordy[i] && mq[i].size() > 0) void'(mq[i].pop_front());
      end
      if (acc) begin
        mq[p_sel].push_back(p_data);
        p_vld = 1'b0;
      end
      #1;
      compare_model("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
